// File: rtl/uart_lite_echo_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_lite_echo_master
// Brief    : AXI4-Lite master that polls a UART Lite, buffers RX bytes in a
//            FIFO and writes them back to TX (optional ASCII case swap).
// Revision : 1.0 - initial release
// ============================================================================
module uart_lite_echo_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 16,
    parameter int          CNT_W     = 16,
    parameter bit          CASE_SWAP = 1'b0,
    parameter bit          INIT_RST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [31:0]      s_axi_awaddr,
    output logic             s_axi_awvalid,
    input  logic             s_axi_awready,
    output logic [31:0]      s_axi_wdata,
    output logic [3:0]       s_axi_wstrb,
    output logic             s_axi_wvalid,
    input  logic             s_axi_wready,
    input  logic [1:0]       s_axi_bresp,
    input  logic             s_axi_bvalid,
    output logic             s_axi_bready,
    output logic [31:0]      s_axi_araddr,
    output logic             s_axi_arvalid,
    input  logic             s_axi_arready,
    input  logic [31:0]      s_axi_rdata,
    input  logic [1:0]       s_axi_rresp,
    input  logic             s_axi_rvalid,
    output logic             s_axi_rready,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] tx_count,
    output logic             err,
    output logic             busy
);

    localparam int          c_PTR_W   = $clog2(DEPTH);
    localparam logic [31:0] c_RX_ADDR = BASE_ADDR + 32'h0;
    localparam logic [31:0] c_TX_ADDR = BASE_ADDR + 32'h4;
    localparam logic [31:0] c_ST_ADDR = BASE_ADDR + 32'h8;
    localparam logic [31:0] c_CT_ADDR = BASE_ADDR + 32'hC;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_INIT_W  = 4'd1,
        S_INIT_B  = 4'd2,
        S_STAT_AR = 4'd3,
        S_STAT_R  = 4'd4,
        S_RX_AR   = 4'd5,
        S_RX_R    = 4'd6,
        S_TX_W    = 4'd7,
        S_TX_B    = 4'd8
    } state_t;

    state_t             r_state, w_next;
    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W:0]   r_wr_ptr, r_rd_ptr;
    logic               r_last_rx, r_init_done;
    logic               w_full, w_empty, w_push, w_pop, w_enter_wr;
    logic               w_ar_hs, w_r_hs, w_b_hs, w_aw_ok, w_w_ok, w_rx_ok, w_tx_ok;
    logic [23:0]        w_unused_rdata;

    function automatic logic [7:0] f_swap(input logic [7:0] b);
        if (CASE_SWAP && ((b >= 8'h61 && b <= 8'h7A) || (b >= 8'h41 && b <= 8'h5A)))
            return b ^ 8'h20;
        return b;
    endfunction

    assign w_unused_rdata = s_axi_rdata[31:8];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                      (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_ar_hs  = s_axi_arvalid & s_axi_arready;
    assign w_r_hs   = s_axi_rvalid & s_axi_rready;
    assign w_b_hs   = s_axi_bvalid & s_axi_bready;
    // a write channel counts as done once its valid has already dropped
    assign w_aw_ok  = ~s_axi_awvalid | s_axi_awready;
    assign w_w_ok   = ~s_axi_wvalid | s_axi_wready;
    assign w_rx_ok  = s_axi_rdata[0] & ~w_full;
    assign w_tx_ok  = ~s_axi_rdata[3] & ~w_empty;
    assign w_push   = (r_state == S_RX_R) & w_r_hs;
    assign w_pop    = (r_state == S_TX_B) & w_b_hs;
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (INIT_RST && !r_init_done) w_next = S_INIT_W;
                else if (enable)              w_next = S_STAT_AR;
            end
            S_INIT_W:  if (w_aw_ok && w_w_ok) w_next = S_INIT_B;
            S_TX_W:    if (w_aw_ok && w_w_ok) w_next = S_TX_B;
            S_INIT_B,
            S_TX_B:    if (w_b_hs) w_next = S_IDLE;
            S_STAT_AR: if (w_ar_hs) w_next = S_STAT_R;
            S_RX_AR:   if (w_ar_hs) w_next = S_RX_R;
            S_RX_R:    if (w_r_hs) w_next = S_IDLE;
            S_STAT_R: begin
                if (w_r_hs) begin
                    if (w_rx_ok && w_tx_ok) w_next = r_last_rx ? S_TX_W : S_RX_AR;
                    else if (w_rx_ok)       w_next = S_RX_AR;
                    else if (w_tx_ok)       w_next = S_TX_W;
                    else if (enable)        w_next = S_STAT_AR;
                    else                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_wr = ((w_next == S_INIT_W) || (w_next == S_TX_W)) && (w_next != r_state);

    // bus outputs are derived from the next state so they leave the register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axi_arvalid <= 1'b0;
            s_axi_rready  <= 1'b0;
            s_axi_bready  <= 1'b0;
            s_axi_awvalid <= 1'b0;
            s_axi_wvalid  <= 1'b0;
            s_axi_wstrb   <= 4'b0000;
            s_axi_araddr  <= 32'h0;
            s_axi_awaddr  <= 32'h0;
            s_axi_wdata   <= 32'h0;
        end else begin
            s_axi_arvalid <= (w_next == S_STAT_AR) || (w_next == S_RX_AR);
            s_axi_rready  <= (w_next == S_STAT_R)  || (w_next == S_RX_R);
            s_axi_bready  <= (w_next == S_INIT_B)  || (w_next == S_TX_B);
            if (w_next == S_STAT_AR)    s_axi_araddr <= c_ST_ADDR;
            else if (w_next == S_RX_AR) s_axi_araddr <= c_RX_ADDR;
            if (w_enter_wr) begin
                s_axi_awvalid <= 1'b1;
                s_axi_wvalid  <= 1'b1;
                s_axi_wstrb   <= 4'b0001;
                if (w_next == S_INIT_W) begin
                    s_axi_awaddr <= c_CT_ADDR;
                    s_axi_wdata  <= 32'h0000_0003;
                end else begin
                    s_axi_awaddr <= c_TX_ADDR;
                    s_axi_wdata  <= {24'h0, f_swap(r_mem[r_rd_ptr[c_PTR_W-1:0]])};
                end
            end else begin
                if (s_axi_awready) s_axi_awvalid <= 1'b0;
                if (s_axi_wready) begin
                    s_axi_wvalid <= 1'b0;
                    s_axi_wstrb  <= 4'b0000;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= s_axi_rdata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            rx_count    <= '0;
            tx_count    <= '0;
            err         <= 1'b0;
            r_last_rx   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                rx_count  <= rx_count + 1'b1;
                r_last_rx <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                tx_count  <= tx_count + 1'b1;
                r_last_rx <= 1'b0;
            end
            if ((w_r_hs && s_axi_rresp != 2'b00) || (w_b_hs && s_axi_bresp != 2'b00))
                err <= 1'b1;
            if ((r_state == S_INIT_B) && w_b_hs)
                r_init_done <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_lite_echo_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_lite_echo_master
// Brief    : Self-checking bench with a behavioural UART Lite slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_lite_echo_master;

    localparam logic [31:0] c_BASE = 32'h4060_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr;
    logic [31:0] s_axi_rdata = 32'h0;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready;
    logic        s_axi_awready = 1'b0, s_axi_wready = 1'b0, s_axi_bvalid = 1'b0;
    logic        s_axi_arready = 1'b0, s_axi_rvalid = 1'b0;
    logic [1:0]  s_axi_bresp = 2'b00, s_axi_rresp = 2'b00;
    logic [15:0] rx_count, tx_count;
    logic        err, busy;

    uart_lite_echo_master #(
        .BASE_ADDR(c_BASE), .DEPTH(16), .CNT_W(16), .CASE_SWAP(1'b1), .INIT_RST(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .rx_count(rx_count), .tx_count(tx_count), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // slave model state
    logic [7:0]  rxq[$];
    logic [7:0]  tx_log[$];
    logic [31:0] wr_addr_log[$], wr_data_log[$];
    logic        txfull = 1'b0, rand_delay = 1'b0, hold_aw = 1'b0, err_next_rx = 1'b0;
    int          stat_reads = 0, rx_reads = 0, prot_err = 0, ctrl_writes = 0, reads_before_wr = -1;
    logic [31:0] first_rd_addr = 32'h0;
    logic        r_pend = 0, aw_got = 0, w_got = 0;
    logic        p_ar = 0, p_r = 0, p_aw = 0, p_w = 0, p_b = 0;
    logic        prev_arv = 0, prev_awv = 0, prev_wv = 0;
    logic [31:0] cap_araddr = 0, cap_awaddr = 0, cap_wdata = 0, aw_addr_q = 0, w_data_q = 0;
    int          ar_wait = 0, aw_wait = 0, w_wait = 0;

    function automatic int pick();
        return rand_delay ? int'($urandom_range(0, 5)) : 0;
    endfunction

    // responses change on the falling edge; handshakes are evaluated on the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            s_axi_arready = 0; s_axi_rvalid = 0; s_axi_rresp = 0; s_axi_awready = 0;
            s_axi_wready = 0; s_axi_bvalid = 0; s_axi_bresp = 0;
            r_pend = 0; aw_got = 0; w_got = 0; p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0;
            prev_arv = 0; prev_awv = 0; prev_wv = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
        end else begin
            if (p_r) begin s_axi_rvalid = 0; r_pend = 0; ar_wait = pick(); end
            if (p_ar) begin
                r_pend = 1; s_axi_rvalid = 1; s_axi_rresp = 2'b00;
                if (stat_reads == 0 && rx_reads == 0) first_rd_addr = cap_araddr;
                if (cap_araddr == c_BASE + 32'h8) begin
                    s_axi_rdata = {28'h0, txfull, 2'b00, (rxq.size() != 0)};
                    stat_reads++;
                end else begin
                    rx_reads++;
                    s_axi_rdata = (rxq.size() != 0) ? {24'h0, rxq.pop_front()} : 32'h0;
                    if (err_next_rx) begin s_axi_rresp = 2'b10; err_next_rx = 0; end
                end
            end
            if (p_b) begin s_axi_bvalid = 0; aw_got = 0; w_got = 0; aw_wait = pick(); w_wait = pick(); end
            if (p_aw) begin aw_got = 1; aw_addr_q = cap_awaddr; end
            if (p_w) begin w_got = 1; w_data_q = cap_wdata; end
            if (aw_got && w_got && !s_axi_bvalid) begin
                if (wr_addr_log.size() == 0) reads_before_wr = stat_reads + rx_reads;
                wr_addr_log.push_back(aw_addr_q);
                wr_data_log.push_back(w_data_q);
                if (aw_addr_q == c_BASE + 32'h4) tx_log.push_back(w_data_q[7:0]);
                if (aw_addr_q == c_BASE + 32'hC) ctrl_writes++;
                s_axi_bvalid = 1; s_axi_bresp = 2'b00;
            end
            if (s_axi_awvalid && aw_got) prot_err++;
            if (s_axi_wvalid && w_got) prot_err++;
            if (s_axi_arvalid && r_pend) prot_err++;
            if (prev_arv && !p_ar && !s_axi_arvalid) prot_err++;
            if (prev_awv && !p_aw && !s_axi_awvalid) prot_err++;
            if (prev_wv && !p_w && !s_axi_wvalid) prot_err++;
            if (s_axi_wvalid && (s_axi_wstrb != 4'b0001 || s_axi_wdata[31:8] != 24'h0)) prot_err++;
            s_axi_arready = 0;
            if (s_axi_arvalid && !r_pend) begin
                if (ar_wait == 0) s_axi_arready = 1; else ar_wait--;
            end
            s_axi_awready = 0;
            if (s_axi_awvalid && !aw_got && !hold_aw) begin
                if (aw_wait == 0) s_axi_awready = 1; else aw_wait--;
            end
            s_axi_wready = 0;
            if (s_axi_wvalid && !w_got) begin
                if (w_wait == 0) s_axi_wready = 1; else w_wait--;
            end
            p_ar = s_axi_arvalid & s_axi_arready; cap_araddr = s_axi_araddr;
            p_r  = s_axi_rvalid & s_axi_rready;
            p_aw = s_axi_awvalid & s_axi_awready; cap_awaddr = s_axi_awaddr;
            p_w  = s_axi_wvalid & s_axi_wready; cap_wdata = s_axi_wdata;
            p_b  = s_axi_bvalid & s_axi_bready;
            prev_arv = s_axi_arvalid; prev_awv = s_axi_awvalid; prev_wv = s_axi_wvalid;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_tx(input int target, input int limit, input string nm);
        int n = 0;
        while (int'(tx_count) != target && n < limit) begin @(posedge clk); #1; n++; end
        chk(nm, 32'(n < limit), 32'd1);
    endtask

    typedef struct { logic [7:0] rx; logic [7:0] tx; } vec_t;
    vec_t vecs[10];
    logic [7:0] burst[20];
    logic [7:0] rin[6], rexp[6];

    initial begin
        int base, rb, n, cw;
        vecs[0] = '{8'h61, 8'h41}; vecs[1] = '{8'h41, 8'h61}; vecs[2] = '{8'h7A, 8'h5A};
        vecs[3] = '{8'h5A, 8'h7A}; vecs[4] = '{8'h40, 8'h40}; vecs[5] = '{8'h5B, 8'h5B};
        vecs[6] = '{8'h60, 8'h60}; vecs[7] = '{8'h7B, 8'h7B}; vecs[8] = '{8'h30, 8'h30};
        vecs[9] = '{8'hE1, 8'hE1};
        rin  = '{8'h62, 8'h59, 8'h21, 8'h7A, 8'h00, 8'hFF};
        rexp = '{8'h42, 8'h79, 8'h21, 8'h5A, 8'h00, 8'hFF};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", 32'(s_axi_arvalid), 0);
        chk("rst_awvalid", 32'(s_axi_awvalid), 0);
        chk("rst_wvalid",  32'(s_axi_wvalid), 0);
        chk("rst_wstrb",   32'(s_axi_wstrb), 0);
        chk("rst_readys",  32'({s_axi_rready, s_axi_bready}), 0);
        chk("rst_addr",    s_axi_awaddr | s_axi_araddr | s_axi_wdata, 0);
        chk("rst_counts",  {rx_count, tx_count}, 0);
        chk("rst_err_busy", 32'({err, busy}), 0);
        #1 rst = 1'b0; enable = 1'b1;

        // init write first, then status polling
        n = 0;
        while (stat_reads == 0 && n < 200) begin @(posedge clk); #1; n++; end
        chk("init_timeout", 32'(n < 200), 1);
        chk("init_awaddr", (wr_addr_log.size() > 0) ? wr_addr_log[0] : 32'hDEAD, c_BASE + 32'hC);
        chk("init_wdata",  (wr_data_log.size() > 0) ? wr_data_log[0] : 32'hDEAD, 32'h3);
        chk("init_first",  32'(reads_before_wr), 0);
        chk("first_araddr", first_rd_addr, c_BASE + 32'h8);
        chk("init_count0", {rx_count, tx_count}, 0);

        // single-byte echo table
        for (int i = 0; i < 10; i++) begin
            base = tx_log.size();
            rxq.push_back(vecs[i].rx);
            wait_tx(i + 1, 300, "vec_timeout");
            chk($sformatf("vec%0d_tx", i), (tx_log.size() > base) ? 32'(tx_log[base]) : 32'hDEAD,
                32'(vecs[i].tx));
            chk($sformatf("vec%0d_rxcnt", i), 32'(rx_count), 32'(i + 1));
        end

        // TX blocked: FIFO fills to DEPTH, rest stays in the UART
        base = tx_log.size(); rb = rx_reads;
        txfull = 1'b1;
        for (int k = 0; k < 20; k++) begin burst[k] = 8'h80 + 8'(k); rxq.push_back(burst[k]); end
        repeat (600) @(posedge clk);
        #1;
        chk("full_rx_reads", 32'(rx_reads - rb), 16);
        chk("full_no_tx", 32'(tx_log.size() - base), 0);
        chk("full_left", 32'(rxq.size()), 4);
        chk("full_busy", 32'(busy), 1);
        txfull = 1'b0;
        wait_tx(30, 2000, "drain_timeout");
        for (int k = 0; k < 20; k++)
            chk($sformatf("drain%0d", k), (tx_log.size() > base + k) ? 32'(tx_log[base + k]) : 32'hDEAD,
                32'(burst[k]));
        chk("drain_rxcnt", 32'(rx_count), 30);

        // randomised ready delays
        rand_delay = 1'b1;
        base = tx_log.size();
        for (int k = 0; k < 6; k++) rxq.push_back(rin[k]);
        wait_tx(36, 3000, "rand_timeout");
        for (int k = 0; k < 6; k++)
            chk($sformatf("rand%0d", k), (tx_log.size() > base + k) ? 32'(tx_log[base + k]) : 32'hDEAD,
                32'(rexp[k]));
        chk("rand_prot", 32'(prot_err), 0);
        rand_delay = 1'b0;

        // error response on an RX read
        chk("err_before", 32'(err), 0);
        err_next_rx = 1'b1;
        rxq.push_back(8'h63);
        wait_tx(37, 300, "err_timeout");
        chk("err_set", 32'(err), 1);
        chk("err_rxcnt", 32'(rx_count), 37);
        chk("err_byte", (tx_log.size() > 0) ? 32'(tx_log[tx_log.size() - 1]) : 32'hDEAD, 32'h43);
        repeat (100) @(posedge clk);
        #1;
        chk("err_sticky", 32'(err), 1);
        chk("init_once", 32'(ctrl_writes), 1);

        // reset while a TX write address is stalled
        hold_aw = 1'b1;
        rxq.push_back(8'h35);
        n = 0;
        while (!s_axi_awvalid && n < 300) begin @(posedge clk); #1; n++; end
        chk("stall_timeout", 32'(n < 300), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_hold", 32'(s_axi_awvalid), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_awvalid", 32'(s_axi_awvalid), 0);
        chk("arst_counts", {rx_count, tx_count}, 0);
        chk("arst_err_busy", 32'({err, busy}), 0);
        base = tx_log.size(); cw = ctrl_writes;
        repeat (3) @(posedge clk);
        #2 hold_aw = 1'b0; rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("post_rst_no_tx", 32'(tx_log.size() - base), 0);
        chk("post_rst_init", 32'(ctrl_writes - cw), 1);
        chk("post_rst_counts", {rx_count, tx_count}, 0);
        chk("final_prot", 32'(prot_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
